fetch_align_ctrl: RTL

- Fetch-stage controller that sequences the instruction decompressor.
- Issues 32-bit word-aligned instruction-memory reads and keeps a halfword-granular PC.
- Splits each fetched word into 16-bit (RVC) and 32-bit instructions, including 32-bit instructions that straddle two words.
- Hands one raw instruction per handshake to the decompressor; compressed instructions are zero-extended. It replaces the ad-hoc PC-minus-4 correction with a proper alignment state machine.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/fetch_half_sel.sv | 43 ++++
 rtl/fetch_align_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared fetch-stage types and constants: FSM states, instruction lengths and the
// RVC length test used by both the picker and the controller.
package cpu_pkg;

    typedef enum logic [1:0] {
        S_REQ     = 2'd0,
        S_WAIT    = 2'd1,
        S_DRAIN   = 2'd2,
        S_DISCARD = 2'd3
    } fetch_state_e;

    localparam logic [1:0] RVC_OP_32 = 2'b11;
    localparam int         ILEN_C    = 16;
    localparam int         ILEN      = 32;

    function automatic logic is_rvc(input logic [15:0] half);
        return half[1:0] != RVC_OP_32;
    endfunction

endpackage

// File: rtl/fetch_half_sel.sv
// Picks the next instruction out of the word buffer (or a straddle splice) and reports its length.
// Latency: purely combinational.
// Backpressure: none; the controller decides when the picked instruction is consumed.
module fetch_half_sel
    import cpu_pkg::*;
#(
    parameter bit C_EN = 1'b1
) (
    input  logic [31:0] word,
    input  logic        hoff,
    input  logic [15:0] lo,
    input  logic        lo_valid,
    output logic [31:0] ins,
    output logic        is_c,
    output logic [2:0]  len,
    output logic        split
);

    logic [15:0] half;
    logic        half_c;

    always_comb begin
        half   = hoff ? word[31:16] : word[15:0];
        half_c = C_EN && is_rvc(half);

        ins   = word;
        is_c  = 1'b0;
        len   = 3'(ILEN / 8);
        split = 1'b0;

        if (lo_valid) begin
            // Upper half of a 32-bit instruction begun in the previous word.
            ins = {word[15:0], lo};
        end else if (half_c) begin
            ins  = {16'h0000, half};
            is_c = 1'b1;
            len  = 3'(ILEN_C / 8);
        end else if (hoff) begin
            split = 1'b1;
        end
    end

endmodule

// File: rtl/fetch_align_ctrl.sv
// Fetch alignment controller: word-aligned imem reads, halfword PC, RVC/32-bit splitting incl. straddles.
// Latency: imem_rvalid_i in cycle N presents the instruction in cycle N+1.
// Backpressure: ins_* held stable while ins_valid_o && !ins_ready_i; no new fetch is issued while draining.
module fetch_align_ctrl
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter bit          C_EN     = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        ins_valid_o,
    input  logic        ins_ready_i,
    output logic [31:0] ins_o,
    output logic [31:0] ins_pc_o,
    output logic        ins_is_c_o
);

    localparam logic [31:0] PC_MASK    = C_EN ? 32'hFFFF_FFFE : 32'hFFFF_FFFC;
    localparam logic [31:0] WORD_MASK  = 32'hFFFF_FFFC;
    localparam logic [31:0] RESET_PCQ  = RESET_PC & PC_MASK;
    localparam logic [31:0] RESET_FA   = RESET_PC & WORD_MASK;
    localparam logic        RESET_HOFF = C_EN & RESET_PC[1];

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  fa_q, fa_d;
    logic [31:0]  word_q, word_d;
    logic         hoff_q, hoff_d;
    logic [15:0]  lo_q, lo_d;
    logic         lo_valid_q, lo_valid_d;
    logic         req_q, req_d;
    logic [31:0]  addr_q, addr_d;

    logic [31:0]  sel_ins;
    logic         sel_is_c;
    logic [2:0]   sel_len;
    logic         sel_split;
    logic         accept;
    logic         outstanding;

    fetch_half_sel #(
        .C_EN(C_EN)
    ) u_half_sel (
        .word     (word_q),
        .hoff     (hoff_q),
        .lo       (lo_q),
        .lo_valid (lo_valid_q),
        .ins      (sel_ins),
        .is_c     (sel_is_c),
        .len      (sel_len),
        .split    (sel_split)
    );

    assign ins_valid_o = (state_q == S_DRAIN) && !sel_split;
    assign accept      = ins_valid_o && ins_ready_i;
    assign ins_o       = ins_valid_o ? sel_ins  : 32'h0;
    assign ins_pc_o    = ins_valid_o ? pc_q     : 32'h0;
    assign ins_is_c_o  = ins_valid_o && sel_is_c;
    assign imem_req_o  = req_q;
    assign imem_addr_o = addr_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        fa_d        = fa_q;
        word_d      = word_q;
        hoff_d      = hoff_q;
        lo_d        = lo_q;
        lo_valid_d  = lo_valid_q;
        outstanding = 1'b0;

        unique case (state_q)
            S_REQ: begin
                // req_q low only in the first cycle after reset: nothing issued yet.
                outstanding = req_q;
                if (req_q) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                outstanding = !imem_rvalid_i;
                if (imem_rvalid_i) begin
                    word_d  = imem_rdata_i;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (lo_valid_q) begin
                    if (accept) begin
                        pc_d       = pc_q + {29'h0, sel_len};
                        hoff_d     = 1'b1;
                        lo_valid_d = 1'b0;
                    end
                end else if (sel_split) begin
                    lo_d       = word_q[31:16];
                    lo_valid_d = 1'b1;
                    fa_d       = fa_q + 32'd4;
                    hoff_d     = 1'b0;
                    state_d    = S_REQ;
                end else if (accept) begin
                    pc_d = pc_q + {29'h0, sel_len};
                    if (!hoff_q && sel_is_c) begin
                        hoff_d = 1'b1;
                    end else begin
                        hoff_d  = 1'b0;
                        fa_d    = fa_q + 32'd4;
                        state_d = S_REQ;
                    end
                end
            end
            S_DISCARD: begin
                outstanding = !imem_rvalid_i;
                if (imem_rvalid_i) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase

        // A response arriving with the redirect is dropped here; only a still-pending one needs discarding.
        if (redirect_i) begin
            pc_d       = redirect_pc_i & PC_MASK;
            fa_d       = redirect_pc_i & WORD_MASK;
            hoff_d     = C_EN & redirect_pc_i[1];
            lo_d       = 16'h0;
            lo_valid_d = 1'b0;
            word_d     = 32'h0;
            state_d    = outstanding ? S_DISCARD : S_REQ;
        end

        req_d  = (state_d == S_REQ);
        addr_d = req_d ? fa_d : addr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PCQ;
            fa_q       <= RESET_FA;
            word_q     <= 32'h0;
            hoff_q     <= RESET_HOFF;
            lo_q       <= 16'h0;
            lo_valid_q <= 1'b0;
            req_q      <= 1'b0;
            addr_q     <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fa_q       <= fa_d;
            word_q     <= word_d;
            hoff_q     <= hoff_d;
            lo_q       <= lo_d;
            lo_valid_q <= lo_valid_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
        end
    end

endmodule
